// File: rtl/lsu_pkg.sv
// Package for the load/store unit: FSM state type, RV32 funct3 encodings
// and helpers that classify a request at accept time.
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR,
      RMW_RD,
      RMW_WR,
      DONE
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Loads accept all five encodings; stores only SB/SH/SW.
   function automatic logic f3_legal(input logic write, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !write;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   // funct3[1:0] carries the access size (00 byte, 01 half, 10 word).
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      case (f3[1:0])
         2'b01:   bad = addr_lo[0];
         2'b10:   bad = |addr_lo;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational byte-lane steering for the load/store unit.
//   funct3     : access type of the latched request
//   addr_lo    : byte offset within the word
//   word       : word captured from memory
//   wdata      : store data (rs2)
//   load_data  : selected lane, sign/zero extended (0 for unknown funct3)
//   store_data : word to write back; SB/SH merge into the captured word
module lsu_data_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      load_data  = '0;
      store_data = wdata;
      byte_sel   = word[{addr_lo, 3'b000} +: 8];
      half_sel   = word[{addr_lo[1], 4'b0000} +: 16];

      case (funct3)
         F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_data = {24'h0, byte_sel};
         F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_data = {16'h0, half_sel};
         F3_W:    load_data = word;
         default: load_data = '0;
      endcase

      case (funct3)
         F3_B: begin
            store_data = word;
            store_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
         end
         F3_H: begin
            store_data = word;
            store_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
         end
         default: store_data = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a byte-addressed, word-wide data memory.
// Takes one RV32 load/store at a time, drives the memory port from registered
// state (so it is stable across the memory's negedge sample), and returns a
// one-cycle response. SB/SH are performed as read-modify-write.
//   Clk, Rst_n                  : clock, async active-low reset
//   Req_Valid/Ready/Write/Funct3/Addr/Wdata : request handshake and fields
//   Resp_Valid/Rdata/Fault      : one-cycle completion pulse, load data, fault
//   Mem_Read/Write/Address/Data_Out/Data_In : memory port
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Req_Valid,
   output logic              Req_Ready,
   input  logic              Req_Write,
   input  logic [2:0]        Req_Funct3,
   input  logic [31:0]       Req_Addr,
   input  logic [DATA_W-1:0] Req_Wdata,
   output logic              Resp_Valid,
   output logic [DATA_W-1:0] Resp_Rdata,
   output logic              Resp_Fault,
   output logic              Mem_Read,
   output logic              Mem_Write,
   output logic [ADDR_W-1:0] Mem_Address,
   output logic [DATA_W-1:0] Mem_Data_Out,
   input  logic [DATA_W-1:0] Mem_Data_In
);

   lsu_state_t        state;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              write_q;
   logic              fault_q;
   logic [31:0]       word_q;
   logic              resp_valid_q;
   logic              resp_fault_q;
   logic [31:0]       resp_rdata_q;

   logic [31:0]       load_data;
   logic [31:0]       store_data;
   logic              accept_fault;
   logic              in_rd;
   logic              in_wr;

   assign accept_fault = !f3_legal(Req_Write, Req_Funct3)
                       || misaligned(Req_Funct3, Req_Addr[1:0])
                       || (|Req_Addr[31:ADDR_W]);

   lsu_data_align u_align (
      .funct3     (funct3_q),
      .addr_lo    (addr_q[1:0]),
      .word       (word_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_data (store_data)
   );

   // Reset forces IDLE asynchronously; gating with Rst_n keeps Ready low while
   // reset is held and lets it rise as soon as reset is released.
   assign Req_Ready = (state == IDLE) && Rst_n;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state        <= IDLE;
         funct3_q     <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         fault_q      <= 1'b0;
         // NOTE: the capture register is a plain flop, not a memory array, so it is cleared with the rest.
         word_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_rdata_q <= '0;
         case (state)
            IDLE: begin
               if (Req_Valid) begin
                  funct3_q <= Req_Funct3;
                  addr_q   <= Req_Addr[ADDR_W-1:0];
                  wdata_q  <= Req_Wdata;
                  write_q  <= Req_Write;
                  fault_q  <= accept_fault;
                  if (accept_fault)           state <= DONE;
                  else if (!Req_Write)        state <= RD;
                  else if (Req_Funct3 == F3_W) state <= WR;
                  else                        state <= RMW_RD;
               end
            end
            RD: begin
               word_q <= Mem_Data_In;
               state  <= DONE;
            end
            RMW_RD: begin
               word_q <= Mem_Data_In;
               state  <= RMW_WR;
            end
            WR, RMW_WR: state <= DONE;
            DONE: begin
               // Response is registered here, so it appears one edge after DONE.
               resp_valid_q <= 1'b1;
               resp_fault_q <= fault_q;
               resp_rdata_q <= (fault_q || write_q) ? '0 : load_data;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_rd        = (state == RD) || (state == RMW_RD);
   assign in_wr        = (state == WR) || (state == RMW_WR);
   assign Mem_Read     = in_rd;
   assign Mem_Write    = in_wr;
   assign Mem_Address  = (in_rd || in_wr) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign Mem_Data_Out = in_wr ? store_data : '0;

   assign Resp_Valid   = resp_valid_q;
   assign Resp_Fault   = resp_fault_q;
   assign Resp_Rdata   = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// responses; a negedge monitor pops and compares data, fault and latency.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam int ADDR_W = 20;

   logic              Clk;
   logic              Rst_n;
   logic              Req_Valid;
   logic              Req_Ready;
   logic              Req_Write;
   logic [2:0]        Req_Funct3;
   logic [31:0]       Req_Addr;
   logic [31:0]       Req_Wdata;
   logic              Resp_Valid;
   logic [31:0]       Resp_Rdata;
   logic              Resp_Fault;
   logic              Mem_Read;
   logic              Mem_Write;
   logic [ADDR_W-1:0] Mem_Address;
   logic [31:0]       Mem_Data_Out;
   logic [31:0]       Mem_Data_In;

   load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .Req_Valid    (Req_Valid),
      .Req_Ready    (Req_Ready),
      .Req_Write    (Req_Write),
      .Req_Funct3   (Req_Funct3),
      .Req_Addr     (Req_Addr),
      .Req_Wdata    (Req_Wdata),
      .Resp_Valid   (Resp_Valid),
      .Resp_Rdata   (Resp_Rdata),
      .Resp_Fault   (Resp_Fault),
      .Mem_Read     (Mem_Read),
      .Mem_Write    (Mem_Write),
      .Mem_Address  (Mem_Address),
      .Mem_Data_Out (Mem_Data_Out),
      .Mem_Data_In  (Mem_Data_In)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- memory model ----------------
   logic [7:0]        mem [0:(1<<ADDR_W)-1];
   int                rd_cycles = 0;
   int                wr_cycles = 0;
   logic [ADDR_W-1:0] last_wr_addr = '0;

   always @(negedge Clk) begin
      if (Mem_Write) begin
         mem[Mem_Address]      <= Mem_Data_Out[7:0];
         mem[Mem_Address + 1]  <= Mem_Data_Out[15:8];
         mem[Mem_Address + 2]  <= Mem_Data_Out[23:16];
         mem[Mem_Address + 3]  <= Mem_Data_Out[31:24];
         wr_cycles    <= wr_cycles + 1;
         last_wr_addr <= Mem_Address;
      end
      if (Mem_Read) begin
         Mem_Data_In <= {mem[Mem_Address + 3], mem[Mem_Address + 2],
                         mem[Mem_Address + 1], mem[Mem_Address]};
         rd_cycles   <= rd_cycles + 1;
      end else begin
         Mem_Data_In <= '0;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          lat;
      time         t_acc;
   } exp_t;

   exp_t sb_q[$];
   int   checks    = 0;
   int   failures  = 0;
   int   issued    = 0;
   int   resp_cnt  = 0;
   int   prev_lat  = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (Rst_n && Resp_Valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("resp%0d_rdata", resp_cnt), Resp_Rdata, e.rdata);
            check($sformatf("resp%0d_fault", resp_cnt), {31'd0, Resp_Fault}, {31'd0, e.fault});
            check($sformatf("resp%0d_latency", resp_cnt),
                  32'(($time - e.t_acc - 5) / 10), 32'(e.lat));
         end
         resp_cnt++;
      end
   end

   // ---------------- driver ----------------
   // Holds Req_Valid high until accepted; when the previous request was issued
   // back-to-back, the cycles spent with Ready low must equal its latency.
   task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_fault, input int exp_lat);
      int   busy;
      logic rdy;
      logic accepted;
      exp_t e;
      busy       = 0;
      accepted   = 1'b0;
      Req_Valid  = 1'b1;
      Req_Write  = wr;
      Req_Funct3 = f3;
      Req_Addr   = addr;
      Req_Wdata  = wdata;
      for (int i = 0; i < 40 && !accepted; i++) begin
         @(negedge Clk);
         rdy = Req_Ready;
         @(posedge Clk);
         if (rdy) accepted = 1'b1;
         else     busy++;
      end
      if (!accepted) begin
         check($sformatf("accept_timeout_req%0d", issued), 32'd0, 32'd1);
      end else begin
         e.rdata = exp_rdata;
         e.fault = exp_fault;
         e.lat   = exp_lat;
         e.t_acc = $time;
         sb_q.push_back(e);
         if (prev_lat >= 0)
            check($sformatf("busy_cycles_req%0d", issued), 32'(busy), 32'(prev_lat));
      end
      issued++;
      prev_lat = exp_lat;
      #1;
   endtask

   task automatic idle();
      Req_Valid = 1'b0;
      prev_lat  = -1;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge Clk);
      check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
      @(posedge Clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int rd0;
      int wr0;
      int resp0;
      Rst_n      = 1'b0;
      Req_Valid  = 1'b0;
      Req_Write  = 1'b0;
      Req_Funct3 = '0;
      Req_Addr   = '0;
      Req_Wdata  = '0;

      // Reset state
      #3;
      check("rst_mem_read",   {31'd0, Mem_Read}, 32'd0);
      check("rst_mem_write",  {31'd0, Mem_Write}, 32'd0);
      check("rst_mem_addr",   32'(Mem_Address), 32'd0);
      check("rst_resp_valid", {31'd0, Resp_Valid}, 32'd0);
      check("rst_resp_rdata", Resp_Rdata, 32'd0);
      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;
      #1;
      check("rst_req_ready", {31'd0, Req_Ready}, 32'd1);
      @(posedge Clk);
      #1;

      // 1: SW then LW
      wr0 = wr_cycles;
      issue(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2);
      idle();
      drain();
      check("sw_write_pulses", 32'(wr_cycles - wr0), 32'd1);
      check("sw_write_addr", 32'(last_wr_addr), 32'h100);
      issue(1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);
      idle();
      drain();

      // 2: SB read-modify-write
      issue(1'b1, F3_W, 32'h100, 32'h11223344, 32'h0, 1'b0, 2);
      rd0 = rd_cycles;
      issue(1'b1, F3_B, 32'h101, 32'hFFFFFF80, 32'h0, 1'b0, 3);
      issue(1'b0, F3_W, 32'h100, 32'h0, 32'h11228044, 1'b0, 2);
      issue(1'b0, F3_B, 32'h101, 32'h0, 32'hFFFFFF80, 1'b0, 2);
      issue(1'b0, F3_BU, 32'h101, 32'h0, 32'h00000080, 1'b0, 2);
      idle();
      drain();
      check("sb_lw_lb_lbu_reads", 32'(rd_cycles - rd0), 32'd4);

      // 3: SH upper half
      issue(1'b1, F3_W, 32'h100, 32'h11223344, 32'h0, 1'b0, 2);
      issue(1'b1, F3_H, 32'h102, 32'h1234BEEF, 32'h0, 1'b0, 3);
      issue(1'b0, F3_W, 32'h100, 32'h0, 32'hBEEF3344, 1'b0, 2);
      issue(1'b0, F3_H, 32'h102, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
      issue(1'b0, F3_HU, 32'h102, 32'h0, 32'h0000BEEF, 1'b0, 2);
      idle();
      drain();

      // 4: faults, no memory traffic
      rd0 = rd_cycles;
      wr0 = wr_cycles;
      issue(1'b0, F3_W, 32'h103, 32'h0, 32'h0, 1'b1, 1);
      issue(1'b1, F3_H, 32'h101, 32'hFFFF, 32'h0, 1'b1, 1);
      issue(1'b0, F3_W, 32'h100000, 32'h0, 32'h0, 1'b1, 1);
      issue(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1);
      issue(1'b1, F3_BU, 32'h100, 32'h0, 32'h0, 1'b1, 1);
      idle();
      drain();
      check("fault_mem_reads", 32'(rd_cycles - rd0), 32'd0);
      check("fault_mem_writes", 32'(wr_cycles - wr0), 32'd0);
      // Highest in-range word, and memory untouched by the faulted SH
      issue(1'b1, F3_W, 32'hFFFFC, 32'hCAFEF00D, 32'h0, 1'b0, 2);
      issue(1'b0, F3_W, 32'hFFFFC, 32'h0, 32'hCAFEF00D, 1'b0, 2);
      issue(1'b0, F3_W, 32'h100, 32'h0, 32'hBEEF3344, 1'b0, 2);
      idle();
      drain();

      // 5: back-to-back mixed traffic, Req_Valid held high throughout
      issue(1'b0, F3_W, 32'h100, 32'h0, 32'hBEEF3344, 1'b0, 2);
      issue(1'b0, F3_W, 32'h101, 32'h0, 32'h0, 1'b1, 1);
      issue(1'b1, F3_B, 32'h103, 32'h0000005A, 32'h0, 1'b0, 3);
      issue(1'b0, F3_BU, 32'h103, 32'h0, 32'h0000005A, 1'b0, 2);
      issue(1'b0, F3_B, 32'h103, 32'h0, 32'h0000005A, 1'b0, 2);
      issue(1'b0, F3_W, 32'h100, 32'h0, 32'h5AEF3344, 1'b0, 2);
      issue(1'b0, F3_H, 32'h100, 32'h0, 32'h00003344, 1'b0, 2);
      issue(1'b0, F3_HU, 32'h101, 32'h0, 32'h0, 1'b1, 1);
      idle();
      drain();
      check("resp_count_matches_issued", 32'(resp_cnt), 32'(issued));

      // 6: reset during RMW_RD
      resp0 = resp_cnt;
      wr0   = wr_cycles;
      Req_Valid  = 1'b1;
      Req_Write  = 1'b1;
      Req_Funct3 = F3_B;
      Req_Addr   = 32'h100;
      Req_Wdata  = 32'h77;
      @(negedge Clk);
      check("rmw_pre_ready", {31'd0, Req_Ready}, 32'd1);
      @(posedge Clk);
      #2;
      Req_Valid = 1'b0;
      check("rmw_rd_mem_read", {31'd0, Mem_Read}, 32'd1);
      Rst_n = 1'b0;
      #1;
      check("midrst_mem_read",   {31'd0, Mem_Read}, 32'd0);
      check("midrst_mem_write",  {31'd0, Mem_Write}, 32'd0);
      check("midrst_mem_addr",   32'(Mem_Address), 32'd0);
      check("midrst_mem_dout",   Mem_Data_Out, 32'd0);
      check("midrst_resp_valid", {31'd0, Resp_Valid}, 32'd0);
      check("midrst_resp_rdata", Resp_Rdata, 32'd0);
      check("midrst_resp_fault", {31'd0, Resp_Fault}, 32'd0);
      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;
      #1;
      check("postrst_req_ready", {31'd0, Req_Ready}, 32'd1);
      repeat (6) @(posedge Clk);
      #1;
      check("postrst_no_response", 32'(resp_cnt - resp0), 32'd0);
      check("postrst_no_write", 32'(wr_cycles - wr0), 32'd0);
      issue(1'b0, F3_W, 32'h100, 32'h0, 32'h5AEF3344, 1'b0, 2);
      idle();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
